uart_tx_arb: RTL and testbench

- Round-robin packet arbiter that shares the single UART transmit FIFO write port between N byte-stream requesters (e.g. command responder, debug logger, status reporter).
- Grants one requester at a time for a whole packet, delimited by last, so bytes from different sources never interleave on the serial line.
- Sits upstream of the TX FIFO. The existing rs232 transmitter drains that FIFO unchanged.

---
 rtl/uart_pkg.sv | 38 +++
 rtl/uart_rr_pick.sv | 17 +
 rtl/uart_tx_arb.sv | 167 ++++++++++++++++
 tb/tb_uart_tx_arb.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types, constants and the rotating-priority helper for the UART TX arbiter.
package uart_pkg;

  // Arbiter FSM encoding; ST_HDR is only reachable when UART_ARB_HDR_EN is defined
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_XFER = 2'd2
  } state_e;

  // Upper nibble of the optional per-packet header byte
  localparam logic [3:0] HDR_TAG = 4'hA;

  // Widest requester set the helper supports
  localparam int unsigned MAX_REQ = 8;

  // One-hot winner: first set bit of req searching ptr, ptr+1, ... modulo n
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                 input logic [2:0]         ptr,
                                                 input int unsigned        n);
    logic [MAX_REQ-1:0] win;
    logic               found;
    logic [2:0]         idx;
    win   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      if (k < n) begin
        idx = 3'(({29'd0, ptr} + k) % n);
        if (!found && req[idx]) begin
          win[idx] = 1'b1;
          found    = 1'b1;
        end
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: combinational N-way rotating priority encoder (one-hot winner).
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] req,
  input  logic [2:0]   rr_ptr,
  output logic [N-1:0] win
);

  // Rotate the search start to rr_ptr and take the first requester found
  always_comb begin
    win = N'(rr_pick(8'(req), rr_ptr, N));
  end

endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin packet arbiter sharing the UART TX FIFO write port between
// N byte-stream sources. A grant is held for a whole packet (until last, a MAX_LEN cut,
// or the source dropping req), so packets never interleave on the serial line.
// Optional build macro: UART_ARB_HDR_EN inserts a {HDR_TAG, 0, src_id} header byte
// ahead of every granted packet.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int unsigned N       = 4,
  parameter int unsigned MAX_LEN = 64,
  parameter int unsigned LEN_W   = 7
) (
  input  logic           clk_50mhz,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   valid,
  input  logic [8*N-1:0] data,
  input  logic [N-1:0]   last,
  output logic [N-1:0]   ready,
  output logic [N-1:0]   grant,
  output logic           wr_clk,
  output logic           wr_en,
  output logic [7:0]     dout,
  input  logic           full,
  output logic           ovf
);

  state_e           state_q;
  logic [2:0]       gidx_q;
  logic [2:0]       rr_ptr_q;
  logic [LEN_W-1:0] cnt_q;

  logic [N-1:0]     win;
  logic [2:0]       win_idx;
  logic [2:0]       next_ptr;
  logic             req_g;
  logic             valid_g;
  logic             last_g;
  logic [7:0]       data_g;
  logic             xfer;
  logic             cnt_max;
  logic             rel;
  logic             ovf_cut;
  logic             hdr_done;

  // The FIFO write side runs on the system clock
  assign wr_clk = clk_50mhz;

  uart_rr_pick #(
    .N (N)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .win    (win)
  );

  // Encode the arbitration winner and select the granted source's lane
  always_comb begin
    win_idx = 3'd0;
    req_g   = 1'b0;
    valid_g = 1'b0;
    last_g  = 1'b0;
    data_g  = 8'd0;
    for (int unsigned i = 0; i < N; i++) begin
      if (win[i]) begin
        win_idx = 3'(i);
      end
      if (grant[i]) begin
        req_g   = req[i];
        valid_g = valid[i];
        last_g  = last[i];
        data_g  = data[8*i +: 8];
      end
    end
  end

  // Pointer moves one past the owner being released
  assign next_ptr = (gidx_q == 3'(N - 1)) ? 3'd0 : gidx_q + 3'd1;

  // FIFO write datapath, handshake and release decisions for the current owner
  always_comb begin
    ready    = '0;
    wr_en    = 1'b0;
    dout     = 8'd0;
    xfer     = 1'b0;
    rel      = 1'b0;
    ovf_cut  = 1'b0;
    hdr_done = 1'b0;
    cnt_max  = (cnt_q == LEN_W'(MAX_LEN - 1));
    unique case (state_q)
`ifdef UART_ARB_HDR_EN
      ST_HDR: begin
        // Header is still written on an abort cycle if the FIFO has room
        if (!full) begin
          wr_en = 1'b1;
          dout  = {HDR_TAG, 1'b0, gidx_q};
        end
        hdr_done = req_g & ~full;
        rel      = ~req_g;
      end
`endif
      ST_XFER: begin
        ready = grant & {N{~full}};
        xfer  = valid_g & ~full;
        if (xfer) begin
          wr_en = 1'b1;
          dout  = data_g;
        end
        // last wins over the length cut, so a final byte at MAX_LEN is a normal end
        rel     = xfer ? (last_g | cnt_max) : ~req_g;
        ovf_cut = xfer & ~last_g & cnt_max;
      end
      default: ;
    endcase
  end

  // Arbiter state machine with registered grant and overflow pulse
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      grant    <= '0;
      gidx_q   <= 3'd0;
      rr_ptr_q <= 3'd0;
      cnt_q    <= '0;
      ovf      <= 1'b0;
    end else begin
      ovf <= ovf_cut;
      unique case (state_q)
        ST_IDLE: begin
          if (|req) begin
            grant  <= win;
            gidx_q <= win_idx;
            cnt_q  <= '0;
`ifdef UART_ARB_HDR_EN
            state_q <= ST_HDR;
`else
            state_q <= ST_XFER;
`endif
          end
        end
`ifdef UART_ARB_HDR_EN
        ST_HDR: begin
          if (hdr_done) begin
            state_q <= ST_XFER;
          end
        end
`endif
        ST_XFER: begin
          if (xfer) begin
            cnt_q <= cnt_q + LEN_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          grant   <= '0;
        end
      endcase
      // Release overrides the per-state updates above; rel is only set in HDR/XFER
      if (rel) begin
        state_q  <= ST_IDLE;
        grant    <= '0;
        rr_ptr_q <= next_ptr;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: directed bench for uart_tx_arb with a packet-level reference model.
// Honours UART_ARB_HDR_EN when the design is built with it.
module tb_uart_tx_arb;

  localparam int N       = 4;
  localparam int MAX_LEN = 4;
  localparam int LEN_W   = 3;
`ifdef UART_ARB_HDR_EN
  localparam bit HdrEn = 1'b1;
`else
  localparam bit HdrEn = 1'b0;
`endif

  logic           clk_50mhz;
  logic           rst_n;
  logic [N-1:0]   req, valid, last, ready, grant;
  logic [8*N-1:0] data;
  logic           wr_clk, wr_en, full, ovf;
  logic [7:0]     dout;

  int checks   = 0;
  int failures = 0;

  uart_tx_arb #(
    .N       (N),
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) dut (
    .clk_50mhz (clk_50mhz),
    .rst_n     (rst_n),
    .req       (req),
    .valid     (valid),
    .data      (data),
    .last      (last),
    .ready     (ready),
    .grant     (grant),
    .wr_clk    (wr_clk),
    .wr_en     (wr_en),
    .dout      (dout),
    .full      (full),
    .ovf       (ovf)
  );

  initial begin
    clk_50mhz = 1'b0;
    forever #10 clk_50mhz = ~clk_50mhz;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- source agents: per-source byte lists ----------------
  logic [8:0] s_mem [N][8];
  int         s_len [N];
  int         s_pos [N];
  int         s_abort [N];
  int         s_stall [N];

  task automatic clear_src();
    for (int i = 0; i < N; i++) begin
      s_len[i] = 0; s_pos[i] = 0; s_abort[i] = -1; s_stall[i] = 0;
    end
  endtask

  task automatic load(input int src, input int n, input logic [7:0] base, input logic [7:0] step,
                      input bit with_last, input int abort_at, input int stall);
    for (int k = 0; k < n; k++) begin
      s_mem[src][k] = {with_last && (k == n - 1), 8'(base + 8'(k) * step)};
    end
    s_len[src] = n; s_pos[src] = 0; s_abort[src] = abort_at; s_stall[src] = stall;
  endtask

  function automatic bit src_done(input int i);
    return (s_pos[i] >= s_len[i]) || (s_pos[i] == s_abort[i]);
  endfunction

  initial begin : agent
    logic [N-1:0] acc;
    req = '0; valid = '0; data = '0; last = '0;
    forever begin
      @(negedge clk_50mhz);
      acc = valid & ready;
      @(posedge clk_50mhz);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i]) s_pos[i]++;
        if (s_stall[i] > 0) s_stall[i]--;
        if (src_done(i)) begin
          req[i] = 1'b0; valid[i] = 1'b0; last[i] = 1'b0; data[8*i +: 8] = 8'd0;
        end else begin
          req[i]         = 1'b1;
          valid[i]       = (s_stall[i] == 0);
          last[i]        = s_mem[i][s_pos[i]][8];
          data[8*i +: 8] = s_mem[i][s_pos[i]][7:0];
        end
      end
    end
  end

  // ---------------- reference model: owner / pointer / byte count ----------------
  int m_owner = -1;
  int m_ptr   = 0;
  int m_cnt   = 0;
  bit m_hdr   = 1'b0;
  bit m_ovf   = 1'b0;

  task automatic m_step();
    bit rel, cut;
    rel = 1'b0; cut = 1'b0;
    if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        if (m_owner < 0 && req[(m_ptr + k) % N]) begin
          m_owner = (m_ptr + k) % N; m_cnt = 0; m_hdr = HdrEn;
        end
      end
    end else if (m_hdr) begin
      if (!req[m_owner]) rel = 1'b1;
      else if (!full) m_hdr = 1'b0;
    end else if (valid[m_owner] && !full) begin
      m_cnt++;
      if (last[m_owner]) rel = 1'b1;
      else if (m_cnt == MAX_LEN) begin rel = 1'b1; cut = 1'b1; end
    end else if (!req[m_owner]) begin
      rel = 1'b1;
    end
    if (rel) begin
      m_ptr = (m_owner + 1) % N; m_owner = -1; m_hdr = 1'b0;
    end
    m_ovf = cut;
  endtask

  initial begin : model
    forever begin
      @(posedge clk_50mhz or negedge rst_n);
      if (!rst_n) begin
        m_owner = -1; m_ptr = 0; m_cnt = 0; m_hdr = 1'b0; m_ovf = 1'b0;
      end else begin
        m_step();
      end
    end
  end

  task automatic m_expect(output logic [N-1:0] e_grant, output logic [N-1:0] e_ready,
                          output logic e_wr, output logic [7:0] e_dout);
    logic [N-1:0] one;
    one = 1;
    e_grant = '0; e_ready = '0; e_wr = 1'b0; e_dout = 8'd0;
    if (m_owner >= 0) begin
      e_grant = one << m_owner;
      if (m_hdr) begin
        if (!full) begin e_wr = 1'b1; e_dout = 8'hA0 | 8'(m_owner); end
      end else if (!full) begin
        e_ready = e_grant;
        if (valid[m_owner]) begin e_wr = 1'b1; e_dout = data[8*m_owner +: 8]; end
      end
    end
  endtask

  // ---------------- compare + logging on every falling edge ----------------
  int           cyc = 0;
  logic [7:0]   got[$];
  int           wr_cyc[$];
  logic [N-1:0] wr_rdy[$];
  int           glog[$];
  int           ovf_cnt = 0;
  int           ovf_cyc = -1;
  logic [N-1:0] prev_grant = '0;
  logic [7:0]   exp[$];

  task automatic clear_logs();
    got.delete(); wr_cyc.delete(); wr_rdy.delete(); glog.delete();
    ovf_cnt = 0; ovf_cyc = -1;
  endtask

  initial begin : compare
    logic [N-1:0] e_grant, e_ready;
    logic         e_wr;
    logic [7:0]   e_dout;
    forever begin
      @(negedge clk_50mhz);
      cyc++;
      m_expect(e_grant, e_ready, e_wr, e_dout);
      chk("cyc_grant", 32'(grant), 32'(e_grant));
      chk("cyc_ready", 32'(ready), 32'(e_ready));
      chk("cyc_wr_en", 32'(wr_en), 32'(e_wr));
      chk("cyc_dout", 32'(dout), 32'(e_dout));
      chk("cyc_ovf", 32'(ovf), 32'(m_ovf));
      if (wr_en) begin got.push_back(dout); wr_cyc.push_back(cyc); wr_rdy.push_back(ready); end
      if (ovf) begin ovf_cnt++; ovf_cyc = cyc; end
      if (grant != '0 && prev_grant == '0) begin
        for (int i = 0; i < N; i++) if (grant[i]) glog.push_back(i);
      end
      prev_grant = grant;
    end
  end

  // ---------------- main sequence helpers ----------------
  task automatic tick();
    @(posedge clk_50mhz);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; clear_src(); full = 1'b0;
    tick(); tick();
    rst_n = 1'b1; clear_logs();
  endtask

  task automatic wait_done(input string name, input int budget);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < budget && !ok; t++) begin
      tick();
      ok = (m_owner < 0);
      for (int i = 0; i < N; i++) if (!src_done(i)) ok = 1'b0;
    end
    checks++;
    if (!ok) begin failures++; $display("FAIL %s: timeout after %0d cycles", name, budget); end
  endtask

  task automatic wait_writes(input string name, input int n, input int budget);
    for (int t = 0; t < budget && got.size() < n; t++) tick();
    checks++;
    if (got.size() < n) begin
      failures++; $display("FAIL %s: writes=%0d required=%0d", name, got.size(), n);
    end
  endtask

  task automatic exp_hdr(input int src);
    if (HdrEn) exp.push_back(8'hA0 | 8'(src));
  endtask

  task automatic chk_got(input string name);
    chk({name, "_count"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++) chk({name, "_byte"}, 32'(got[i]), 32'(exp[i]));
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int first;
    first = HdrEn ? 2 : 1;
    full = 1'b0; rst_n = 1'b1; clear_src();
    #1 rst_n = 1'b0;
    tick(); tick();
    chk("rst_grant", 32'(grant), 0);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_dout", 32'(dout), 0);
    chk("rst_ovf", 32'(ovf), 0);
    rst_n = 1'b1; clear_logs(); tick();

    // Single source 1: 0x11, 0x22, 0x33 (last)
    do_reset();
    load(1, 3, 8'h11, 8'h11, 1'b1, -1, 0);
    tick(); chk("t1_grant_arb", 32'(grant), 0);
    tick(); chk("t1_grant", 32'(grant), 32'h2);
    wait_done("t1_done", 40);
    exp.delete(); exp_hdr(1); exp.push_back(8'h11); exp.push_back(8'h22); exp.push_back(8'h33);
    chk_got("t1");
    if (wr_cyc.size() > 0) chk("t1_back_to_back", 32'(wr_cyc[$] - wr_cyc[0]), 32'(got.size() - 1));
    chk("t1_ptr", 32'(m_ptr), 2);
    chk("t1_grant_end", 32'(grant), 0);

    // Round robin: all four request, source 0 has two 1-byte packets
    do_reset();
    load(0, 2, 8'h40, 8'h04, 1'b1, -1, 0);
    s_mem[0][0][8] = 1'b1;
    load(1, 1, 8'h41, 8'h00, 1'b1, -1, 0);
    load(2, 1, 8'h42, 8'h00, 1'b1, -1, 0);
    load(3, 1, 8'h43, 8'h00, 1'b1, -1, 0);
    wait_done("t2_done", 80);
    chk("t2_grants", 32'(glog.size()), 5);
    if (glog.size() == 5) begin
      chk("t2_g0", 32'(glog[0]), 0); chk("t2_g1", 32'(glog[1]), 1);
      chk("t2_g2", 32'(glog[2]), 2); chk("t2_g3", 32'(glog[3]), 3);
      chk("t2_g4", 32'(glog[4]), 0);
    end
    exp.delete();
    exp_hdr(0); exp.push_back(8'h40); exp_hdr(1); exp.push_back(8'h41);
    exp_hdr(2); exp.push_back(8'h42); exp_hdr(3); exp.push_back(8'h43);
    exp_hdr(0); exp.push_back(8'h44);
    chk_got("t2");

    // Backpressure: full for 5 cycles after the first data byte
    do_reset();
    load(2, 3, 8'h31, 8'h01, 1'b1, -1, 0);
    wait_writes("t3_first", first, 20);
    full = 1'b1;
    for (int t = 0; t < 5; t++) begin
      #1;
      chk("t3_ready_full", 32'(ready), 0);
      chk("t3_wr_full", 32'(wr_en), 0);
      tick();
    end
    full = 1'b0;
    wait_done("t3_done", 40);
    exp.delete(); exp_hdr(2); exp.push_back(8'h31); exp.push_back(8'h32); exp.push_back(8'h33);
    chk_got("t3");

    // Overflow: 6 bytes without last, cut at MAX_LEN=4, rest served on re-request
    do_reset();
    load(0, 6, 8'h61, 8'h01, 1'b0, -1, 0);
    wait_done("t4_done", 80);
    exp.delete();
    exp_hdr(0); for (int k = 0; k < 4; k++) exp.push_back(8'(8'h61 + k));
    exp_hdr(0); exp.push_back(8'h65); exp.push_back(8'h66);
    chk_got("t4");
    chk("t4_ovf_count", 32'(ovf_cnt), 1);
    if (wr_cyc.size() > first + 2) chk("t4_ovf_at", 32'(ovf_cyc - wr_cyc[first + 2]), 1);
    chk("t4_regrants", 32'(glog.size()), 2);
    // 4 bytes with last on byte 4, after a valid-low stall under grant
    clear_logs();
    load(1, 4, 8'h71, 8'h01, 1'b1, -1, 3);
    wait_done("t4b_done", 60);
    exp.delete(); exp_hdr(1); for (int k = 0; k < 4; k++) exp.push_back(8'(8'h71 + k));
    chk_got("t4b");
    chk("t4b_ovf_count", 32'(ovf_cnt), 0);

    // Abort: source 2 drops req after 2 of 5 bytes; next pick starts at 3
    do_reset();
    load(2, 5, 8'h81, 8'h01, 1'b1, 2, 0);
    wait_done("t5_done", 40);
    exp.delete(); exp_hdr(2); exp.push_back(8'h81); exp.push_back(8'h82);
    chk_got("t5");
    chk("t5_ovf_count", 32'(ovf_cnt), 0);
    chk("t5_ptr", 32'(m_ptr), 3);
    clear_logs(); clear_src();
    load(0, 1, 8'h91, 8'h00, 1'b1, -1, 0);
    load(3, 1, 8'h93, 8'h00, 1'b1, -1, 0);
    wait_done("t5b_done", 40);
    chk("t5b_grants", 32'(glog.size()), 2);
    if (glog.size() == 2) begin
      chk("t5b_g0", 32'(glog[0]), 3); chk("t5b_g1", 32'(glog[1]), 0);
    end

    // Reset asserted mid-packet
    do_reset();
    load(1, 4, 8'hB1, 8'h01, 1'b1, -1, 0);
    wait_writes("t6_first", first, 20);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_grant", 32'(grant), 0);
    chk("t6_wr_en", 32'(wr_en), 0);
    chk("t6_ovf", 32'(ovf), 0);
    chk("t6_ready", 32'(ready), 0);
    clear_src();
    tick(); tick();
    rst_n = 1'b1; clear_logs();

    // Source 3 single byte 0x55 (header 0xA3 first when enabled)
    do_reset();
    load(3, 1, 8'h55, 8'h00, 1'b1, -1, 0);
    wait_done("t7_done", 40);
    exp.delete(); exp_hdr(3); exp.push_back(8'h55);
    chk_got("t7");
    if (wr_rdy.size() == exp.size()) begin
`ifdef UART_ARB_HDR_EN
      chk("t7_hdr_ready", 32'(wr_rdy[0]), 0);
      chk("t7_data_ready", 32'(wr_rdy[1]), 32'h8);
`else
      chk("t7_data_ready", 32'(wr_rdy[0]), 32'h8);
`endif
    end

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
